// File: rtl/uart_tx_frame.sv
// uart_tx_frame: UART transmit framer. It sends one parallel word per frame on
// TX_OUT, one bit per CLK cycle. Each frame is a start bit (0), DATA_WD data
// bits sent LSB first, an optional parity bit, and one stop bit (1).
//
// Ports
//   CLK         TX bit-rate clock
//   RST         synchronous, active-high reset
//   P_DATA      word to send; sampled only on accept
//   DATA_VALID  send request; honoured only while BUSY=0
//   PAR_EN      1 = append a parity bit; sampled only on accept
//   PAR_TYP     0 = even parity, 1 = odd parity; sampled only on accept
//   TX_OUT      registered serial line; idles high
//   BUSY        registered; high from the start bit through the stop bit
module uart_tx_frame #(
  parameter int DATA_WD = 8
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [DATA_WD-1:0] P_DATA,
  input  logic               DATA_VALID,
  input  logic               PAR_EN,
  input  logic               PAR_TYP,
  output logic               TX_OUT,
  output logic               BUSY
);

  localparam int CNT_W = $clog2(DATA_WD);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WD - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  // Same convention as the RX checker: even -> XOR of the data, odd -> XNOR.
  function automatic logic parity_calc(input logic [DATA_WD-1:0] word, input logic odd);
    return odd ? ~^word : ^word;
  endfunction

  state_t               state_r, state_s;
  logic [CNT_W-1:0]     cnt_r, cnt_s;
  logic [DATA_WD-1:0]   data_r, data_s;
  logic                 par_en_r, par_en_s;
  logic                 par_bit_r, par_bit_s;
  logic                 tx_r, tx_s;
  logic                 busy_r, busy_s;

  // Next-state logic. The line value for the next cycle is computed here and
  // registered, so TX_OUT and BUSY come straight from flops. data_r shifts
  // right once per data bit, so bit 0 always holds the next bit to send.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    data_s    = data_r;
    par_en_s  = par_en_r;
    par_bit_s = par_bit_r;
    tx_s      = 1'b1;
    busy_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (DATA_VALID) begin
          data_s    = P_DATA;
          par_en_s  = PAR_EN;
          par_bit_s = parity_calc(P_DATA, PAR_TYP);
          state_s   = ST_START;
          cnt_s     = {CNT_W{1'b0}};
          tx_s      = 1'b0;
          busy_s    = 1'b1;
        end else begin
          tx_s   = 1'b1;
          busy_s = 1'b0;
        end
      end
      ST_START: begin
        state_s = ST_DATA;
        cnt_s   = {CNT_W{1'b0}};
        tx_s    = data_r[0];
        data_s  = {1'b0, data_r[DATA_WD-1:1]};
        busy_s  = 1'b1;
      end
      ST_DATA: begin
        busy_s = 1'b1;
        if (cnt_r == CNT_LAST) begin
          cnt_s = {CNT_W{1'b0}};
          if (par_en_r) begin
            state_s = ST_PARITY;
            tx_s    = par_bit_r;
          end else begin
            state_s = ST_STOP;
            tx_s    = 1'b1;
          end
        end else begin
          cnt_s  = cnt_r + CNT_W'(1);
          tx_s   = data_r[0];
          data_s = {1'b0, data_r[DATA_WD-1:1]};
        end
      end
      ST_PARITY: begin
        state_s = ST_STOP;
        tx_s    = 1'b1;
        busy_s  = 1'b1;
      end
      ST_STOP: begin
        // No accept here: the following idle cycle is the minimum gap.
        state_s = ST_IDLE;
        tx_s    = 1'b1;
        busy_s  = 1'b0;
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = {CNT_W{1'b0}};
        tx_s    = 1'b1;
        busy_s  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any frame in progress.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r   <= ST_IDLE;
      cnt_r     <= {CNT_W{1'b0}};
      data_r    <= {DATA_WD{1'b0}};
      par_en_r  <= 1'b0;
      par_bit_r <= 1'b0;
      tx_r      <= 1'b1;
      busy_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      data_r    <= data_s;
      par_en_r  <= par_en_s;
      par_bit_r <= par_bit_s;
      tx_r      <= tx_s;
      busy_r    <= busy_s;
    end
  end

  assign TX_OUT = tx_r;
  assign BUSY   = busy_r;

endmodule
